// File: rtl/nand_n_bist.sv
// rtl/nand_n_bist.sv - exhaustive self-test engine for an external N-input gate
//
// Steps the gate inputs x through every value 0 .. 2^N-1. Each vector is held
// for WAIT settle cycles plus one check cycle; z_obs is sampled at the end of
// the check cycle and compared with the expected reduction of the vector.
//
// Optional feature macro: NAND_BIST_MULTI_GATE_EN
//   undefined : expected function is always NAND
//   defined   : adds gate_sel[2:0], captured with start
//               (0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 NAND)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   begin a run; only honoured while idle
//   gate_sel      in   [2:0] expected-function select (feature macro only)
//   z_obs         in   output of the gate under test
//   x             out  [N-1:0] stimulus vector to the gate inputs
//   busy          out  run in progress
//   done          out  run finished; held until the next accepted start
//   pass          out  valid with done; 1 = no mismatches in the run
//   err_count     out  [ERR_W-1:0] mismatches in the last run, saturating
//   first_err_vec out  [N-1:0] vector of the first mismatch
module nand_n_bist #(
  parameter int N     = 2,
  parameter int WAIT  = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef NAND_BIST_MULTI_GATE_EN
  input  logic [2:0]       gate_sel,
`endif
  input  logic             z_obs,
  output logic [N-1:0]     x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N-1:0]     first_err_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK
  } state_t;

  // The settle counter is loaded with WAIT-1 so SETTLE spans exactly WAIT
  // cycles; with WAIT=0 the settle phase is skipped entirely.
  localparam logic [7:0]       SETTLE_LOAD = (WAIT > 0) ? 8'(WAIT - 1) : 8'd0;
  localparam state_t           RUN_STATE   = (WAIT > 0) ? S_SETTLE : S_CHECK;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q, state_d;
  logic [N-1:0]     vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N-1:0]     fev_q, fev_d;
  logic             exp_z;
  logic             mismatch;

`ifdef NAND_BIST_MULTI_GATE_EN
  logic [2:0] sel_q, sel_d;

  always_comb begin
    exp_z = ~&vec_q;
    case (sel_q)
      3'd0:    exp_z = &vec_q;
      3'd1:    exp_z = |vec_q;
      3'd3:    exp_z = ~|vec_q;
      3'd4:    exp_z = ^vec_q;
      3'd5:    exp_z = ~^vec_q;
      default: exp_z = ~&vec_q;
    endcase
  end
`else
  assign exp_z = ~&vec_q;
`endif

  assign mismatch = (z_obs != exp_z);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
`ifdef NAND_BIST_MULTI_GATE_EN
    sel_d   = sel_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fev_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = SETTLE_LOAD;
          state_d = RUN_STATE;
`ifdef NAND_BIST_MULTI_GATE_EN
          sel_d   = gate_sel;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          // err_count never returns to zero within a run, so a zero count
          // marks the first mismatch even after saturation.
          if (err_q == '0) begin
            fev_d = vec_q;
          end
        end
        // Termination on all-ones avoids relying on the counter wrapping.
        if (&vec_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0) && !mismatch;
          state_d = S_IDLE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = SETTLE_LOAD;
          state_d = RUN_STATE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= '0;
`ifdef NAND_BIST_MULTI_GATE_EN
      sel_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
`ifdef NAND_BIST_MULTI_GATE_EN
      sel_q   <= sel_d;
`endif
    end
  end

  assign x             = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vec = fev_q;

endmodule
